ps2_keyboard_tx: RTL and testbench

//  Device-side PS/2 transmitter: emulates a keyboard by serialising scan-code bytes onto ps2_clk/ps2_data.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_tx_fifo.sv | 55 +++++
 rtl/ps2_keyboard_tx.sv | 142 ++++++++++++++
 tb/tb_ps2_keyboard_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame layout, FSM encoding and a frame builder.
// The break code is exported for benches that emit key-release sequences.
package ps2_pkg;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic       PS2_START_BIT  = 1'b0;
  localparam logic       PS2_STOP_BIT   = 1'b1;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HIGH,
    ST_LOW,
    ST_GAP
  } ps2_state_e;

  // Bit 0 goes on the wire first; parity is odd over the data byte.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_make_frame(input logic [7:0] data);
    return {PS2_STOP_BIT, ~^data, data, PS2_START_BIT};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO with registered read: pop_data is valid the cycle after pop.
// A full FIFO rejects pushes even when a pop happens in the same cycle.
module ps2_tx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [7:0]    rd_data_reg;
  logic          do_push;
  logic          do_pop;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign count    = count_reg;
  assign pop_data = rd_data_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (do_pop) rd_data_reg <= mem[rd_ptr_reg];
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 transmitter: serialises buffered scan-code bytes as 11-bit
// frames on registered ps2_clk/ps2_data, with a forced idle gap after each frame.
module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 100,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          ps2_clk,
  output logic          ps2_data,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e                state_reg, state_next;
  logic [DW-1:0]             div_cnt_reg, div_cnt_next;
  logic [GW-1:0]             gap_cnt_reg, gap_cnt_next;
  logic [3:0]                bit_idx_reg, bit_idx_next;
  logic [PS2_FRAME_BITS-1:0] frame_reg, frame_next;
  logic                      ps2_clk_reg, ps2_clk_next;
  logic                      ps2_data_reg, ps2_data_next;

  logic       fifo_pop;
  logic [7:0] fifo_rd_data;
  logic       fifo_full;
  logic       fifo_empty;

  assign in_ready = ~fifo_full;

  ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      div_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
      bit_idx_reg  <= '0;
      frame_reg    <= '1;
      ps2_clk_reg  <= 1'b1;
      ps2_data_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      frame_reg    <= frame_next;
      ps2_clk_reg  <= ps2_clk_next;
      ps2_data_reg <= ps2_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    bit_idx_next = bit_idx_reg;
    frame_next   = frame_reg;
    fifo_pop     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_LOAD;
        end
      end
      // Registered FIFO read lands here, one cycle after the pop.
      ST_LOAD: begin
        frame_next   = ps2_make_frame(fifo_rd_data);
        bit_idx_next = '0;
        div_cnt_next = '0;
        state_next   = ST_HIGH;
      end
      ST_HIGH: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          state_next   = ST_LOW;
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      ST_LOW: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          if (bit_idx_reg == BIT_LAST) begin
            gap_cnt_next = '0;
            state_next   = ST_GAP;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
            state_next   = ST_HIGH;
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) state_next = ST_IDLE;
        else gap_cnt_next = gap_cnt_reg + 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line outputs follow the state by one cycle; data changes only at the
  // start of HIGH so it is stable across the whole HIGH+LOW bit period.
  always_comb begin
    ps2_clk_next  = (state_reg != ST_LOW);
    ps2_data_next = ps2_data_reg;
    if (state_reg == ST_HIGH && div_cnt_reg == '0)
      ps2_data_next = frame_reg[bit_idx_reg];
    else if (state_reg == ST_IDLE || state_reg == ST_GAP)
      ps2_data_next = 1'b1;
  end

  assign ps2_clk  = ps2_clk_reg;
  assign ps2_data = ps2_data_reg;
  assign busy     = (state_reg != ST_IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Directed bench for ps2_keyboard_tx: a line monitor decodes frames at ps2_clk
// falls; results are compared against hand-computed frames and timings.
module tb_ps2_keyboard_tx;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 10;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int rx_i     = 0;

  logic [10:0] rx_frame_q[$];
  int          rx_fall_q[$];
  logic [7:0]  exp_q[$];

  logic        mon_prev = 1'b1;
  int          mon_n    = 0;
  logic [10:0] mon_sh   = '0;
  int          mon_ffall = 0;

  ps2_keyboard_tx #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: sample data on each ps2_clk fall, 11 bits per frame.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_n    = 0;
        mon_prev = 1'b1;
      end else begin
        if (mon_prev && !ps2_clk) begin
          mon_sh[mon_n] = ps2_data;
          if (mon_n == 0) mon_ffall = cyc;
          mon_n++;
          if (mon_n == 11) begin
            rx_frame_q.push_back(mon_sh);
            rx_fall_q.push_back(mon_ffall);
            mon_n = 0;
          end
        end
        mon_prev = ps2_clk;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
  endfunction

  // Leaves in_valid asserted so callers can chain back-to-back pushes.
  task automatic push_byte(input logic [7:0] b);
    logic ok;
    bit   done = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 1000 && !done; n++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        done    = 1;
        acc_cyc = cyc;
        exp_q.push_back(b);
      end
    end
    if (!done) check("push_timeout", 0, 1);
    $display("push byte=%02h at cycle %0d", b, acc_cyc);
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx_frame_q.size() < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (rx_frame_q.size() < n) check("rx_timeout", rx_frame_q.size(), n);
  endtask

  // Next received frame against a hand-computed 11-bit frame.
  task automatic expect_hand(input string tag, input logic [10:0] exp_frame);
    wait_rx(rx_i + 1);
    if (rx_frame_q.size() > rx_i) begin
      check(tag, rx_frame_q[rx_i], exp_frame);
      $display("rx frame=%03h byte=%02h", rx_frame_q[rx_i], rx_frame_q[rx_i][8:1]);
      rx_i++;
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic expect_frames(input int n);
    logic [7:0] e;
    wait_rx(rx_i + n);
    for (int i = 0; i < n; i++) begin
      if (rx_frame_q.size() > rx_i && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stream_byte", rx_frame_q[rx_i][8:1], e);
        check("stream_framing", frame_ok(rx_frame_q[rx_i]), 1);
        $display("rx frame=%03h byte=%02h exp=%02h", rx_frame_q[rx_i], rx_frame_q[rx_i][8:1], e);
        rx_i++;
      end
    end
  endtask

  task automatic wait_line(input logic want_clk, input logic want_data, output int at);
    int t = 0;
    at = -1;
    while (t < 2000 && at < 0) begin
      @(negedge clk);
      if (ps2_clk == want_clk && ps2_data == want_data) at = cyc;
      t++;
    end
    if (at < 0) check("line_timeout", 0, 1);
  endtask

  // The stop bit's rising clock edge appears one cycle after the FSM enters
  // GAP, and busy falls as the FSM returns to IDLE: GAP_CYCLES-1 samples apart.
  task automatic check_gap(input string tag);
    int   r;
    int   t = 0;
    logic all_hi = 1'b1;
    wait_line(1'b1, 1'b1, r);
    while (busy && t < 500) begin
      @(negedge clk);
      all_hi &= ps2_clk & ps2_data;
      t++;
    end
    check({tag, "_len"}, cyc - r, GAP_CYCLES - 1);
    check({tag, "_idle"}, all_hi, 1);
  endtask

  initial begin
    int r;
    int d;
    int base;
    int t;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ps2_clk", ps2_clk, 1);
    check("rst_ps2_data", ps2_data, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1C: bits on the wire 0,0,0,1,1,1,0,0,0,0,1 -> frame 11'h438
    push_byte(8'h1C);
    in_valid = 1'b0;
    check("t1_count", fifo_count, 1);
    check("t1_busy", busy, 1);
    expect_hand("t1_frame_1c", 11'h438);
    check("t1_first_fall", rx_fall_q[rx_i-1] - acc_cyc, CLK_DIV + 3);

    // Both have even data weight, so parity must be 1.
    push_byte(8'h00);
    in_valid = 1'b0;
    expect_hand("t2_frame_00", 11'h600);
    check_gap("t2_gap_00");
    push_byte(8'hFF);
    in_valid = 1'b0;
    expect_hand("t2_frame_ff", 11'h7FE);
    check_gap("t2_gap_ff");

    // Back-to-back F0,1C: next start bit follows the stop-bit clock rise by GAP_CYCLES+2.
    push_byte(8'hF0);
    push_byte(8'h1C);
    in_valid = 1'b0;
    wait_rx(rx_i + 1);
    wait_line(1'b1, 1'b1, r);
    wait_line(1'b1, 1'b0, d);
    check("t3_gap_to_start", d - r, GAP_CYCLES + 2);
    expect_hand("t3_frame_f0", 11'h7E0);
    expect_hand("t3_frame_1c", 11'h438);

    // Fill the FIFO while the first frame is on the wire.
    push_byte(8'h12);
    in_valid = 1'b0;
    wait_line(1'b1, 1'b0, r);
    push_byte(8'h34);
    push_byte(8'h56);
    push_byte(8'h78);
    push_byte(8'h9A);
    check("t4_full_count", fifo_count, 4);
    check("t4_full_ready", in_ready, 0);
    push_byte(8'hBC);
    push_byte(8'hDE);
    in_valid = 1'b0;
    expect_frames(7);

    // Reset mid-frame while a second byte is still queued.
    push_byte(8'h1C);
    push_byte(8'h77);
    in_valid = 1'b0;
    t = 0;
    while (!(mon_n == 5 && ps2_clk == 1'b1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("t5_reach_bit5", mon_n, 5);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_ps2_clk", ps2_clk, 1);
    check("t5_ps2_data", ps2_data, 1);
    check("t5_count", fifo_count, 0);
    check("t5_busy", busy, 0);
    reset = 1'b0;
    exp_q.delete();
    base = rx_frame_q.size();
    repeat (200) @(posedge clk);
    #1;
    check("t5_no_stray_frame", rx_frame_q.size(), base);
    rx_i = base;
    push_byte(8'h1C);
    in_valid = 1'b0;
    expect_hand("t5_frame_1c", 11'h438);
    check("t5_first_fall", rx_fall_q[rx_i-1] - acc_cyc, CLK_DIV + 3);

    // Random loopback stream.
    for (int i = 0; i < 8; i++) push_byte(8'($urandom_range(0, 255)));
    in_valid = 1'b0;
    expect_frames(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
